// File: rtl/rr_ring_arbiter_if.sv
// Requester/resource bundle for rr_ring_arbiter: requests and beat handshake in,
// registered grant, priority pointer and beat count out.
interface rr_ring_arbiter_if #(
  parameter int N       = 4,
  parameter int QUANTUM = 4
) ();
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(QUANTUM + 1);

  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          beat;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  ptr;
  logic [CW-1:0] beat_cnt;

  modport master (
    output req, last, beat,
    input  grant, grant_valid, grant_idx, ptr, beat_cnt
  );

  modport slave (
    input  req, last, beat,
    output grant, grant_valid, grant_idx, ptr, beat_cnt
  );
endinterface

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a per-grant
// beat quantum; every output comes straight from a register.
module rr_ring_arbiter #(
  parameter  int N       = 4,
  parameter  int QUANTUM = 4,
  localparam int IW      = $clog2(N),
  localparam int CW      = $clog2(QUANTUM + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_ring_arbiter_if.slave      bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state;
  logic [N-1:0]  r_grant, w_grant;
  logic          r_valid, w_valid;
  logic [IW-1:0] r_idx, w_idx;
  logic [N-1:0]  r_ptr, w_ptr;
  logic [CW-1:0] r_cnt, w_cnt;

  logic [IW-1:0] w_ptr_idx;
  logic [IW-1:0] w_pos;
  logic [IW-1:0] w_pick_idx;
  logic          w_found;
  logic          w_req_i;
  logic          w_last_i;
  logic          w_at_quantum;

  // Circular scan starting at the pointer position; first set request wins.
  always_comb begin
    w_ptr_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_ptr[k]) w_ptr_idx = IW'(k);
    end
    w_found    = 1'b0;
    w_pick_idx = '0;
    w_pos      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = IW'((32'(w_ptr_idx) + k) % N);
      if (!w_found && bus.req[w_pos]) begin
        w_found    = 1'b1;
        w_pick_idx = w_pos;
      end
    end
  end

  assign w_req_i      = bus.req[r_idx];
  assign w_last_i     = bus.last[r_idx];
  assign w_at_quantum = (r_cnt == CW'(QUANTUM - 1));

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_valid = r_valid;
    w_idx   = r_idx;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_GRANT;
          w_grant = N'(1) << w_pick_idx;
          w_valid = 1'b1;
          w_idx   = w_pick_idx;
          w_cnt   = '0;
        end
      end
      S_GRANT: begin
        // A beat always counts, even if the requester has already dropped req.
        if ((!bus.beat && !w_req_i) || (bus.beat && (w_last_i || w_at_quantum))) begin
          w_state = S_IDLE;
          w_grant = '0;
          w_valid = 1'b0;
          w_idx   = '0;
          w_cnt   = '0;
          w_ptr   = {r_grant[N-2:0], r_grant[N-1]};
        end else if (bus.beat) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= N'(1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_valid <= w_valid;
      r_idx   <= w_idx;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_valid;
  assign bus.grant_idx   = r_idx;
  assign bus.ptr         = r_ptr;
  assign bus.beat_cnt    = r_cnt;

endmodule
